sap_io_ctrl: RTL and testbench
==============================

// Module: sap_io_ctrl
// PURPOSE
//  Parametrised I/O and run-control front end between the SAP-2 core and the chip pins.
//  - Gates the core with a clock enable: run, halt or single-step.
//  - Latches N_OUT core output ports and muxes one onto the output pins.
//  - Captures async pin input data with a strobe/ack handshake for the core to read.
// PARAMETERS
//  DATA_W       8  width of data ports and latches
//  N_OUT        2  number of core output ports (>=1)
//  SYNC_STAGES  2  flops per async-input synchroniser (>=2)
// PORTS
//  clk             in   1                   system clock
//  rst_n           in   1                   async active-low reset
//  run_i           in   1                   async pin: 1=free run, 0=stop
//  step_i          in   1                   async pin: rising edge = one core cycle when stopped
//  cpu_halt_i      in   1                   core HLT decoded
//  cpu_ce_o        out  1                   clock enable to core
//  cpu_out_we_i    in   1                   core OUT write strobe
//  cpu_out_port_i  in   $clog2(N_OUT+1)     core OUT port index
//  cpu_out_data_i  in   DATA_W              core OUT data
//  cpu_in_re_i     in   1                   core IN read strobe
//  cpu_in_data_o   out  DATA_W              captured input byte
//  cpu_in_valid_o  out  1                   input buffer full
//  pin_in_data_i   in   DATA_W              async pin data
//  pin_in_stb_i    in   1                   async pin strobe; rising edge captures data
//  pin_in_ack_o    out  1                   1 = buffer empty, external side may strobe
//  pin_overrun_o   out  1                   sticky: strobe arrived while buffer full
//  pin_out_sel_i   in   $clog2(N_OUT+1)     selects latch shown on pins
//  pin_out_data_o  out  DATA_W              registered selected output
//  state_o         out  2                   FSM state
// BEHAVIOUR
//  Reset values:
//  - State STOP; cpu_ce_o=0; all out latches=0; in buffer=0.
//  - cpu_in_valid_o=0; pin_in_ack_o=1; pin_overrun_o=0; pin_out_data_o=0.
//  Synchronisers:
//  - run_i, step_i and pin_in_stb_i each pass SYNC_STAGES flops plus a rise detect.
//  - Edge pulse is 1 cycle, SYNC_STAGES+1 cycles after the pin edge.
//  FSM (cpu_ce_o is combinational from state):
//  - STOP(0): run_s=1 -> RUN; else step_rise -> STEP.
//  - STEP(1): cpu_ce_o=1 for exactly this cycle -> STOP.
//    If cpu_halt_i=1 in this cycle -> HALT.
//  - RUN(2): cpu_ce_o=1. Precedence: cpu_halt_i=1 -> HALT, else run_s=0 -> STOP.
//  - HALT(3): cpu_ce_o=0. Left only by reset; run/step ignored.
//  Output latches:
//  - Write when cpu_out_we_i & cpu_ce_o; out_reg[cpu_out_port_i] <= cpu_out_data_i.
//  - Port index >= N_OUT: write ignored.
//  - pin_out_data_o <= out_reg[pin_out_sel_i], 1-cycle latency.
//  - Out-of-range select reads 0 (see CONFIGURATION).
//  Input handshake:
//  - stb_rise & !valid: buffer <= pin data sampled that cycle; valid <= 1.
//  - External data must be stable >= SYNC_STAGES+1 cycles before the strobe edge.
//  - cpu_in_re_i & cpu_ce_o & valid: clears valid. Data stays readable, not cleared.
//  - Read and stb_rise in the same cycle: old byte consumed, new byte captured, valid stays 1.
//  - stb_rise & valid & no read: byte dropped; pin_overrun_o set until reset.
//  - pin_in_ack_o = !cpu_in_valid_o.
//  - Read with valid=0: no effect.
//  Async reset mid-operation returns every register to its reset value immediately.
// CONFIGURATION
//  SAP_IO_CYCLE_CNT_EN defined:
//  - Adds a DATA_W-bit counter, +1 every cycle cpu_ce_o=1, wraps to 0, reset to 0.
//  - Readable via pin_out_sel_i == N_OUT.
//  SAP_IO_CYCLE_CNT_EN undefined:
//  - No counter; select N_OUT reads 0.
// STRUCTURE
//  sap_io_pkg: typedef enum logic [1:0] {STOP,STEP,RUN,HALT} sap_io_state_t.
//  sap_io_sync: sub-module, SYNC_STAGES flops + rise detect; instantiated 3x.
// TESTING
//  - Reset, run_i=1 -> cpu_ce_o=1 from cycle 4 (SYNC_STAGES=2), state_o=2.
//  - run_i=0 then 3 step_i pulses -> exactly 3 single-cycle cpu_ce_o pulses, state_o returns to 0.
//  - RUN, cpu_halt_i=1 for one cycle -> HALT; cpu_ce_o=0; run/step toggles ignored until rst_n.
//  - OUT port1=0xA5, port0=0x3C, write to port 2 (N_OUT=2) -> sel=1 gives 0xA5, sel=0 gives 0x3C.
//    sel=2 gives 0, or the cycle count with SAP_IO_CYCLE_CNT_EN.
//  - Strobe 0x11 then 0x22 without read -> cpu_in_data_o=0x11, overrun=1.
//    Read -> valid=0, ack=1.
//  - Read coincident with stb_rise of 0x77 -> cpu_in_data_o=0x77, valid stays 1, no overrun.

Source files
------------

// File: rtl/sap_io_pkg.sv
// Shared types for the SAP-2 I/O and run-control front end.
package sap_io_pkg;

    // Run-control states; the encoding is visible on state_o.
    typedef enum logic [1:0] {
        STOP = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } sap_io_state_t;

    // The core is clocked only while single-stepping or free running.
    function automatic logic state_clocks_core(input sap_io_state_t s);
        return (s == STEP) || (s == RUN);
    endfunction

endpackage

// File: rtl/sap_io_sync.sv
// Synchroniser for one asynchronous pin: SYNC_STAGES flops, then a rise detect.
// level_o is the synchronised level. rise_o is a one-cycle pulse that is
// acted on at the (SYNC_STAGES+1)th clock edge after the pin rises.
module sap_io_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the pin through the synchroniser and remember the last synchronised level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, forming a real shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/sap_io_ctrl.sv
// I/O and run-control front end between the SAP-2 core and the chip pins:
// clock-enable run control, latched OUT ports muxed onto the pins, and a
// one-byte input buffer filled by an asynchronous strobe/ack handshake.
// Optional build macro SAP_IO_CYCLE_CNT_EN adds a core-cycle counter that is
// readable on the pins at select value N_OUT.
module sap_io_ctrl
    import sap_io_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int N_OUT       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         run_i,
    input  logic                         step_i,
    input  logic                         cpu_halt_i,
    output logic                         cpu_ce_o,
    input  logic                         cpu_out_we_i,
    input  logic [$clog2(N_OUT+1)-1:0]   cpu_out_port_i,
    input  logic [DATA_W-1:0]            cpu_out_data_i,
    input  logic                         cpu_in_re_i,
    output logic [DATA_W-1:0]            cpu_in_data_o,
    output logic                         cpu_in_valid_o,
    input  logic [DATA_W-1:0]            pin_in_data_i,
    input  logic                         pin_in_stb_i,
    output logic                         pin_in_ack_o,
    output logic                         pin_overrun_o,
    input  logic [$clog2(N_OUT+1)-1:0]   pin_out_sel_i,
    output logic [DATA_W-1:0]            pin_out_data_o,
    output logic [1:0]                   state_o
);

    localparam int PORT_W = $clog2(N_OUT + 1);

    sap_io_state_t    state;
    sap_io_state_t    state_nxt;
    logic             run_s;
    logic             run_rise;
    logic             step_s;
    logic             step_rise;
    logic             stb_s;
    logic             stb_rise;
    logic [DATA_W-1:0] out_reg [N_OUT];
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] in_buf;
    logic             in_valid;
    logic             overrun;
    logic             in_read;

    sap_io_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (run_i),
        .level_o (run_s),
        .rise_o  (run_rise)
    );

    sap_io_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (step_i),
        .level_o (step_s),
        .rise_o  (step_rise)
    );

    sap_io_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stb (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (pin_in_stb_i),
        .level_o (stb_s),
        .rise_o  (stb_rise)
    );

    // Run is level-controlled, step and strobe are edge-controlled; the rest is unused.
    logic unused_sync;
    assign unused_sync = &{1'b0, run_rise, step_s, stb_s};

    // Run-control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state rules; halt has priority over stop, and HALT is left only by reset.
    always_comb begin
        // NOTE: assigning a default first means every path drives state_nxt, so no latch is inferred.
        state_nxt = state;
        case (state)
            STOP: begin
                if (run_s) begin
                    state_nxt = RUN;
                end else if (step_rise) begin
                    state_nxt = STEP;
                end
            end
            STEP:    state_nxt = cpu_halt_i ? HALT : STOP;
            RUN: begin
                if (cpu_halt_i) begin
                    state_nxt = HALT;
                end else if (!run_s) begin
                    state_nxt = STOP;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = STOP;
        endcase
    end

    // Core clock enable decoded straight from the state.
    always_comb begin
        cpu_ce_o = state_clocks_core(state);
    end

    assign state_o = state;

    // OUT latches: only a clocked core cycle may write, and out-of-range ports match no latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these latches are few and must read 0 after reset, so they are reset like plain flops rather than built as RAM.
            for (int i = 0; i < N_OUT; i++) begin
                out_reg[i] <= '0;
            end
        end else if (cpu_out_we_i && cpu_ce_o) begin
            for (int i = 0; i < N_OUT; i++) begin
                if (cpu_out_port_i == PORT_W'(i)) begin
                    out_reg[i] <= cpu_out_data_i;
                end
            end
        end
    end

`ifdef SAP_IO_CYCLE_CNT_EN
    logic [DATA_W-1:0] cycle_cnt;

    // Count clocked core cycles, wrapping at the data width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else if (cpu_ce_o) begin
            cycle_cnt <= cycle_cnt + DATA_W'(1);
        end
    end
`endif

    // Pin readback select: a latch, the cycle counter when built in, otherwise 0.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (pin_out_sel_i == PORT_W'(i)) begin
                sel_data = out_reg[i];
            end
        end
`ifdef SAP_IO_CYCLE_CNT_EN
        if (pin_out_sel_i == PORT_W'(N_OUT)) begin
            sel_data = cycle_cnt;
        end
`endif
    end

    // Register the selected value onto the output pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_out_data_o <= '0;
        end else begin
            pin_out_data_o <= sel_data;
        end
    end

    // A read counts only on a clocked core cycle with a byte waiting.
    assign in_read = cpu_in_re_i && cpu_ce_o && in_valid;

    // Input buffer: capture on strobe when empty or being emptied, otherwise flag the loss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_buf   <= '0;
            in_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (stb_rise && (!in_valid || in_read)) begin
                in_buf   <= pin_in_data_i;
                in_valid <= 1'b1;
            end else if (in_read) begin
                in_valid <= 1'b0;
            end
            if (stb_rise && in_valid && !in_read) begin
                overrun <= 1'b1;
            end
        end
    end

    assign cpu_in_data_o  = in_buf;
    assign cpu_in_valid_o = in_valid;
    assign pin_in_ack_o   = !in_valid;
    assign pin_overrun_o  = overrun;

endmodule

// File: tb/tb_sap_io_ctrl.sv
// Bench for sap_io_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a cycle-level model built from pin histories.
module tb_sap_io_ctrl;
    import sap_io_pkg::*;

    localparam int DATA_W      = 8;
    localparam int N_OUT       = 2;
    localparam int SYNC_STAGES = 2;
    localparam int PORT_W      = $clog2(N_OUT + 1);
`ifdef SAP_IO_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              run_i = 1'b0;
    logic              step_i = 1'b0;
    logic              cpu_halt_i = 1'b0;
    logic              cpu_ce_o;
    logic              cpu_out_we_i = 1'b0;
    logic [PORT_W-1:0] cpu_out_port_i = '0;
    logic [DATA_W-1:0] cpu_out_data_i = '0;
    logic              cpu_in_re_i = 1'b0;
    logic [DATA_W-1:0] cpu_in_data_o;
    logic              cpu_in_valid_o;
    logic [DATA_W-1:0] pin_in_data_i = '0;
    logic              pin_in_stb_i = 1'b0;
    logic              pin_in_ack_o;
    logic              pin_overrun_o;
    logic [PORT_W-1:0] pin_out_sel_i = '0;
    logic [DATA_W-1:0] pin_out_data_o;
    logic [1:0]        state_o;

    sap_io_ctrl #(
        .DATA_W      (DATA_W),
        .N_OUT       (N_OUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run_i          (run_i),
        .step_i         (step_i),
        .cpu_halt_i     (cpu_halt_i),
        .cpu_ce_o       (cpu_ce_o),
        .cpu_out_we_i   (cpu_out_we_i),
        .cpu_out_port_i (cpu_out_port_i),
        .cpu_out_data_i (cpu_out_data_i),
        .cpu_in_re_i    (cpu_in_re_i),
        .cpu_in_data_o  (cpu_in_data_o),
        .cpu_in_valid_o (cpu_in_valid_o),
        .pin_in_data_i  (pin_in_data_i),
        .pin_in_stb_i   (pin_in_stb_i),
        .pin_in_ack_o   (pin_in_ack_o),
        .pin_overrun_o  (pin_overrun_o),
        .pin_out_sel_i  (pin_out_sel_i),
        .pin_out_data_o (pin_out_data_o),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. Histories hold the pin value seen at each past clock
    // edge, newest at bit 0: a synchronised level is the value from
    // SYNC_STAGES edges back, and a rise is that value being 1 while the one
    // before it was 0.
    sap_io_state_t       m_st;
    logic [DATA_W-1:0]   m_out [N_OUT];
    logic [DATA_W-1:0]   m_pin_out;
    logic [DATA_W-1:0]   m_cnt;
    logic [DATA_W-1:0]   m_buf;
    logic                m_valid;
    logic                m_ovr;
    logic [SYNC_STAGES:0] h_run;
    logic [SYNC_STAGES:0] h_step;
    logic [SYNC_STAGES:0] h_stb;

    task automatic model_reset();
        m_st      = STOP;
        for (int i = 0; i < N_OUT; i++) m_out[i] = '0;
        m_pin_out = '0;
        m_cnt     = '0;
        m_buf     = '0;
        m_valid   = 1'b0;
        m_ovr     = 1'b0;
        h_run     = '0;
        h_step    = '0;
        h_stb     = '0;
    endtask

    // Advance the model across one clock edge using the inputs held before it.
    task automatic model_edge();
        bit ce, run_s, step_rise, stb_rise, rd;
        int port, sel;
        ce        = (m_st == STEP) || (m_st == RUN);
        run_s     = h_run[SYNC_STAGES-1];
        step_rise = h_step[SYNC_STAGES-1] && !h_step[SYNC_STAGES];
        stb_rise  = h_stb[SYNC_STAGES-1] && !h_stb[SYNC_STAGES];
        port      = int'(cpu_out_port_i);
        sel       = int'(pin_out_sel_i);

        if (sel < N_OUT)                  m_pin_out = m_out[sel];
        else if (CNT_EN && sel == N_OUT)  m_pin_out = m_cnt;
        else                              m_pin_out = '0;

        if (cpu_out_we_i && ce && port < N_OUT) m_out[port] = cpu_out_data_i;
        if (ce) m_cnt = m_cnt + 1'b1;

        rd = cpu_in_re_i && ce && m_valid;
        if (stb_rise && m_valid && !rd) begin
            m_ovr = 1'b1;
        end else if (stb_rise) begin
            m_buf   = pin_in_data_i;
            m_valid = 1'b1;
        end else if (rd) begin
            m_valid = 1'b0;
        end

        case (m_st)
            STOP:    m_st = run_s ? RUN : (step_rise ? STEP : STOP);
            STEP:    m_st = cpu_halt_i ? HALT : STOP;
            RUN:     m_st = cpu_halt_i ? HALT : (run_s ? RUN : STOP);
            default: m_st = HALT;
        endcase

        h_run  = {h_run[SYNC_STAGES-1:0], run_i};
        h_step = {h_step[SYNC_STAGES-1:0], step_i};
        h_stb  = {h_stb[SYNC_STAGES-1:0], pin_in_stb_i};
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".ce"},      cpu_ce_o,       32'((m_st == STEP) || (m_st == RUN)));
        check({ph, ".state"},   state_o,        32'(m_st));
        check({ph, ".valid"},   cpu_in_valid_o, 32'(m_valid));
        check({ph, ".ack"},     pin_in_ack_o,   32'(!m_valid));
        check({ph, ".overrun"}, pin_overrun_o,  32'(m_ovr));
        check({ph, ".in_data"}, cpu_in_data_o,  32'(m_buf));
        check({ph, ".pin_out"}, pin_out_data_o, 32'(m_pin_out));
    endtask

    // One clock edge: model and DUT advance together, outputs compared on the falling edge.
    task automatic tick(input string ph);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all(ph);
    endtask

    // Assert reset mid-cycle and check that outputs clear before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rst");
        check("rst.state_now", state_o, 32'd0);
        check("rst.ack_now",   pin_in_ack_o, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int ce_pulses;

    initial begin
        model_reset();
        do_reset();

        // Free run: enable appears on the third edge after run_i rises.
        run_i = 1'b1;
        tick("run1"); check("run.ce_edge1", cpu_ce_o, 32'd0);
        tick("run2"); check("run.ce_edge2", cpu_ce_o, 32'd0);
        tick("run3"); check("run.ce_edge3", cpu_ce_o, 32'd1);
        check("run.state", state_o, 32'd2);

        // OUT latches, including an ignored write to an out-of-range port.
        cpu_out_we_i = 1'b1;
        cpu_out_port_i = 2'd1; cpu_out_data_i = 8'hA5; tick("out_w1");
        cpu_out_port_i = 2'd0; cpu_out_data_i = 8'h3C; tick("out_w0");
        cpu_out_port_i = 2'd2; cpu_out_data_i = 8'hFF; tick("out_w2");
        cpu_out_we_i = 1'b0;
        pin_out_sel_i = 2'd1; tick("sel1"); check("sel1.const", pin_out_data_o, 32'hA5);
        pin_out_sel_i = 2'd0; tick("sel0"); check("sel0.const", pin_out_data_o, 32'h3C);
        pin_out_sel_i = 2'd2; tick("sel2");
        if (!CNT_EN) check("sel2.const", pin_out_data_o, 32'h00);
        pin_out_sel_i = 2'd3; tick("sel3"); check("sel3.const", pin_out_data_o, 32'h00);

        // Two strobes without a read: first byte kept, overrun flagged; then a read empties.
        pin_in_data_i = 8'h11;
        pin_in_stb_i = 1'b1; repeat (4) tick("stb11_hi");
        pin_in_stb_i = 1'b0; repeat (4) tick("stb11_lo");
        pin_in_data_i = 8'h22;
        pin_in_stb_i = 1'b1; repeat (4) tick("stb22_hi");
        pin_in_stb_i = 1'b0; repeat (2) tick("stb22_lo");
        check("ovr.data",    cpu_in_data_o,  32'h11);
        check("ovr.flag",    pin_overrun_o,  32'd1);
        cpu_in_re_i = 1'b1; tick("read"); cpu_in_re_i = 1'b0;
        check("read.valid",  cpu_in_valid_o, 32'd0);
        check("read.ack",    pin_in_ack_o,   32'd1);

        // Halt from RUN: stays halted whatever run/step do.
        cpu_halt_i = 1'b1; tick("halt"); cpu_halt_i = 1'b0;
        check("halt.state", state_o, 32'd3);
        for (int i = 0; i < 20; i++) begin
            run_i  = 1'($urandom_range(0, 1));
            step_i = 1'($urandom_range(0, 1));
            tick("halt_hold");
        end
        check("halt.hold_state", state_o, 32'd3);
        check("halt.hold_ce",    cpu_ce_o, 32'd0);

        // Single step: three step edges give exactly three enable cycles.
        run_i = 1'b0; step_i = 1'b0;
        do_reset();
        ce_pulses = 0;
        for (int p = 0; p < 3; p++) begin
            step_i = 1'b1;
            repeat (2) begin tick("step_hi"); ce_pulses += int'(cpu_ce_o); end
            step_i = 1'b0;
            repeat (4) begin tick("step_lo"); ce_pulses += int'(cpu_ce_o); end
        end
        check("step.pulses", 32'(ce_pulses), 32'd3);
        check("step.state",  state_o, 32'd0);

        // Read in the same cycle as a new strobe edge: new byte replaces old, no overrun.
        do_reset();
        run_i = 1'b1; repeat (3) tick("run_again");
        pin_in_data_i = 8'h55;
        pin_in_stb_i = 1'b1; repeat (4) tick("stb55_hi");
        pin_in_stb_i = 1'b0; repeat (3) tick("stb55_lo");
        pin_in_data_i = 8'h77; repeat (3) tick("d77_setup");
        pin_in_stb_i = 1'b1;
        tick("coin1"); tick("coin2");
        cpu_in_re_i = 1'b1; tick("coin_rd"); cpu_in_re_i = 1'b0;
        check("coin.data",    cpu_in_data_o,  32'h77);
        check("coin.valid",   cpu_in_valid_o, 32'd1);
        check("coin.overrun", pin_overrun_o,  32'd0);
        pin_in_stb_i = 1'b0;

        // Randomized traffic with periodic resets (halt would otherwise stick).
        for (int c = 0; c < 1500; c++) begin
            if (c % 250 == 249) do_reset();
            if ($urandom_range(0, 19) == 0) run_i = ~run_i;
            if ($urandom_range(0, 3) == 0)  step_i = ~step_i;
            if ($urandom_range(0, 5) == 0)  pin_in_stb_i = ~pin_in_stb_i;
            if ($urandom_range(0, 4) == 0)  pin_in_data_i = DATA_W'($urandom);
            cpu_halt_i     = ($urandom_range(0, 149) == 0);
            cpu_out_we_i   = ($urandom_range(0, 2) == 0);
            cpu_out_port_i = PORT_W'($urandom_range(0, 3));
            cpu_out_data_i = DATA_W'($urandom);
            cpu_in_re_i    = ($urandom_range(0, 3) == 0);
            pin_out_sel_i  = PORT_W'($urandom_range(0, 3));
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
